spi_button_rx: RTL
==================

# spi_button_rx

Receives the controller button word from the USB-host microcontroller over a 3-wire SPI-style link (sck, mosi, cs_n), validates it, and presents a stable 16-bit word to the 3DO pad serializer's `i[15:0]` input. All link pins are asynchronous to `system_clock` and are oversampled. A watchdog forces a released-button word if the MCU stops sending. Bit 1 = pressed.

## Interface
- `IDLE_VALUE`, 16'h0000: word driven on `buttons` after reset and after link timeout.
- `TIMEOUT_CYCLES`, 2_000_000: system_clock cycles without a good frame before timeout (100 ms at 20 MHz).
- `SYNC_STAGES`, 2: flip-flops in each pin synchronizer (≥2).
- `system_clock  in  1`: the block's only clock, 20 MHz.
- `reset  in  1`: synchronous, active-high.
- `sck  in  1`: link clock from MCU, async, idle low; mosi sampled on its rising edge.
- `mosi  in  1`: link data, MSB first.
- `cs_n  in  1`: frame enable, active low, async.
- `buttons  out  16`: last validated word; feeds the pad serializer's `i`.
- `frame_valid  out  1`: one-cycle pulse when `buttons` is updated by a good frame.
- `frame_err  out  1`: one-cycle pulse when a frame is rejected.
- `link_ok  out  1`: 1 while a good frame arrived within the last `TIMEOUT_CYCLES`.

## Operation
- Frame: 24 bits inside one cs_n-low window: data[15:0] MSB first, then check[7:0] = data[15:8] ^ data[7:0] ^ 8'hA5.
- States: IDLE, SHIFT, CHECK.
  - IDLE: wait for synchronized cs_n falling edge -> SHIFT, bit counter = 0, shift register = 0.
  - SHIFT: each synchronized sck rising edge shifts mosi in, counter +1 (5-bit, saturates at 25). cs_n rising edge -> CHECK.
  - CHECK (one cycle): good if counter == 24 and check matches -> load `buttons`, pulse `frame_valid`, reload watchdog, `link_ok`=1. Otherwise pulse `frame_err`, `buttons` unchanged. -> IDLE.
- Counter 25 (overflow) or <24 (short frame) both reject.
- sck rise and cs_n rise detected in the same cycle: cs_n wins, the bit is discarded.
- sck edges while in IDLE are ignored.
- Watchdog: counts up each cycle, saturates at `TIMEOUT_CYCLES`; at reaching it `buttons` = `IDLE_VALUE`, `link_ok` = 0 (same cycle the count hits the limit). Rejected frames do not reload it.
- Reset: state IDLE, counter 0, watchdog 0, outputs `buttons`=`IDLE_VALUE`, `frame_valid`=0, `frame_err`=0, `link_ok`=0. Reset mid-frame discards the frame; if cs_n is low when reset releases, the block waits for a cs_n high then a fresh falling edge.

## Timing
- Pin-to-detected-edge: `SYNC_STAGES`+1 cycles (synchronizer + edge register).
- cs_n rise detected in cycle N: CHECK in N+1; `buttons`/`frame_valid`/`frame_err` registered, visible N+2.
- `buttons` changes only in the cycle `frame_valid` is asserted or at timeout; never mid-frame (pad serializer may latch at any time).
- Link constraint: sck high and low ≥ 3 system_clock cycles each (sck ≤ 3.3 MHz); cs_n high ≥ 3 cycles between frames; mosi stable ≥ 3 cycles around sck rise.

## Structure
- Shared package: `FRAME_BITS`=24, `DATA_BITS`=16, `CHECK_XOR`=8'hA5, state enum (IDLE, SHIFT, CHECK), check-byte function.
- Sub-module `pin_sync`: `SYNC_STAGES` synchronizer plus rise/fall edge pulses; instantiated for sck, mosi (level only), cs_n.
- Top: FSM, shift register, bit counter, watchdog.

## Test plan
- Good frame data 16'hC006, check 8'h63 -> `frame_valid` one pulse, `buttons`=16'hC006, `link_ok`=1, `frame_err`=0.
- Data 16'h1234 with check 8'h84 (correct 8'h83) -> `frame_err` pulse, `buttons` keeps previous 16'hC006.
- 23-bit frame, then 25-bit frame -> `frame_err` pulse each; next good 16'h1234/8'h83 frame -> `buttons`=16'h1234.
- `TIMEOUT_CYCLES`=1000, one good frame then silence -> exactly 1000 cycles after the load `buttons`=16'h0000, `link_ok`=0; next good frame restores both.
- Reset asserted after 10 bits of a frame, released with cs_n low -> rest of that frame ignored (no pulses), outputs at reset values; following good frame accepted.
- Final sck rise coincident with cs_n rise (same cycle after sync) -> bit dropped, 23 bits counted, `frame_err` pulse.

Source files
------------

// File: rtl/spi_button_rx_pkg.sv
// Shared types and constants for the SPI button-word receiver.
// Frame layout: data[15:0] MSB first, then check[7:0].
package spi_button_rx_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned DATA_BITS  = 16;
    localparam logic [7:0]  CHECK_XOR  = 8'hA5;

    localparam int unsigned CNT_BITS = 5;
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FRAME_BITS);
    localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } state_e;

    function automatic logic [7:0] check_byte(input logic [DATA_BITS-1:0] data);
        return data[15:8] ^ data[7:0] ^ CHECK_XOR;
    endfunction

endpackage

// File: rtl/spi_button_rx_if.sv
// Link pins from the MCU plus the validated button word towards the pad serializer.
interface spi_button_rx_if;

    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic [15:0] buttons;
    logic        frame_valid;
    logic        frame_err;
    logic        link_ok;

    modport slave (
        input  sck,
        input  mosi,
        input  cs_n,
        output buttons,
        output frame_valid,
        output frame_err,
        output link_ok
    );

    modport master (
        output sck,
        output mosi,
        output cs_n,
        input  buttons,
        input  frame_valid,
        input  frame_err,
        input  link_ok
    );

endinterface

// File: rtl/spi_button_rx_pin_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with registered rise/fall pulses.
module spi_button_rx_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
        fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_button_rx.sv
// Receives the 24-bit button frame over the SPI-style link, validates it and holds the word
// stable for the pad serializer; a watchdog reverts to IDLE_VALUE when frames stop.
module spi_button_rx
    import spi_button_rx_pkg::*;
#(
    parameter logic [15:0] IDLE_VALUE     = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic           system_clock,
    input  logic           reset,
    spi_button_rx_if.slave bus
);

    localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES);

    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_pins;

    // cs_n resets to "low" so a frame already in progress at reset release cannot
    // produce a falling edge; only a high-then-low sequence opens a new frame.
    spi_button_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i   (system_clock),
        .reset_i (reset),
        .pin_i   (bus.sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_button_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i   (system_clock),
        .reset_i (reset),
        .pin_i   (bus.mosi),
        .level_o (mosi_level),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    spi_button_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk_i   (system_clock),
        .reset_i (reset),
        .pin_i   (bus.cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    assign unused_pins = ^{sck_level, sck_fall, mosi_rise, mosi_fall, cs_level};

    state_e                  state_q, state_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [WD_BITS-1:0]      wd_q, wd_d;
    logic [DATA_BITS-1:0]    buttons_q, buttons_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    link_ok_q, link_ok_d;
    logic                    frame_good;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            shreg_q       <= '0;
            wd_q          <= '0;
            buttons_q     <= IDLE_VALUE;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            link_ok_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            wd_q          <= wd_d;
            buttons_q     <= buttons_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            link_ok_q     <= link_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StShift;
            StShift: if (cs_rise) state_d = StCheck;
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign frame_good = (cnt_q == CNT_FULL) &&
                        (shreg_q[7:0] == check_byte(shreg_q[FRAME_BITS-1:8]));

    always_comb begin
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        wd_d          = wd_q;
        buttons_d     = buttons_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        link_ok_d     = link_ok_q;

        if (state_q == StIdle && cs_fall) begin
            cnt_d   = '0;
            shreg_d = '0;
        end
        // A coincident cs_n rise ends the frame and drops the sck bit.
        if (state_q == StShift && !cs_rise && sck_rise) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_level};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end

        if (wd_q != WD_LIMIT) begin
            wd_d = wd_q + 1'b1;
            if (wd_q + 1'b1 == WD_LIMIT) begin
                buttons_d = IDLE_VALUE;
                link_ok_d = 1'b0;
            end
        end

        if (state_q == StCheck) begin
            if (frame_good) begin
                buttons_d     = shreg_q[FRAME_BITS-1:8];
                frame_valid_d = 1'b1;
                link_ok_d     = 1'b1;
                wd_d          = '0;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign bus.buttons     = buttons_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.link_ok     = link_ok_q;

endmodule
